// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the single SDRAM controller request port between one write client
// (ROM download loader) and NUM_PORTS read clients. Writes always win; reads
// are granted round-robin. Exactly one SDRAM transaction is in flight at a
// time, and every output comes straight from a register.
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic                            wr_req,
    output logic                            wr_ack,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] rd_addr,
    input  logic [NUM_PORTS-1:0]            rd_req,
    output logic [NUM_PORTS-1:0]            rd_ack,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_q,
    output logic [ADDR_WIDTH-1:0]           sdram_addr,
    output logic [DATA_WIDTH-1:0]           sdram_data,
    output logic                            sdram_we,
    output logic                            sdram_req,
    input  logic                            sdram_ack,
    input  logic                            sdram_valid,
    input  logic [DATA_WIDTH-1:0]           sdram_q
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA
    } state_t;

    state_t                  state, state_nxt;

    // Round-robin pointer holds the last granted read port; search starts one above it.
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [PTR_W-1:0]        grant, grant_nxt;
    logic                    is_wr, is_wr_nxt;

    logic [ADDR_WIDTH-1:0]   sdram_addr_nxt;
    logic [DATA_WIDTH-1:0]   sdram_data_nxt;
    logic                    sdram_we_nxt;
    logic                    sdram_req_nxt;
    logic                    wr_ack_nxt;
    logic [NUM_PORTS-1:0]    rd_ack_nxt;
    logic [NUM_PORTS-1:0]    rd_valid_nxt;
    logic [DATA_WIDTH-1:0]   rd_q_nxt;

    logic [ADDR_WIDTH-1:0]   rd_addr_arr [NUM_PORTS];
    logic                    rd_hit;
    logic [PTR_W-1:0]        rd_sel;
    int                      cand;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign rd_addr_arr[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Round-robin search: first asserted rd_req from rr_ptr+1 upward, wrapping.
    always_comb begin
        rd_hit = 1'b0;
        rd_sel = '0;
        cand   = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(rr_ptr) + i) % NUM_PORTS;
            if (!rd_hit && rd_req[PTR_W'(cand)]) begin
                rd_hit = 1'b1;
                rd_sel = PTR_W'(cand);
            end
        end
    end

    // Next-state and next-output logic; pulses default low, held values default to current.
    always_comb begin
        state_nxt      = state;
        rr_ptr_nxt     = rr_ptr;
        grant_nxt      = grant;
        is_wr_nxt      = is_wr;
        sdram_addr_nxt = sdram_addr;
        sdram_data_nxt = sdram_data;
        sdram_we_nxt   = sdram_we;
        sdram_req_nxt  = sdram_req;
        wr_ack_nxt     = 1'b0;
        rd_ack_nxt     = '0;
        rd_valid_nxt   = '0;
        rd_q_nxt       = rd_q;

        case (state)
            ST_IDLE: begin
                // Stray sdram_ack/sdram_valid are ignored here by construction.
                if (wr_req) begin
                    is_wr_nxt      = 1'b1;
                    sdram_addr_nxt = wr_addr;
                    sdram_data_nxt = wr_data;
                    sdram_we_nxt   = 1'b1;
                    sdram_req_nxt  = 1'b1;
                    state_nxt      = ST_REQ;
                end else if (rd_hit) begin
                    is_wr_nxt      = 1'b0;
                    grant_nxt      = rd_sel;
                    rr_ptr_nxt     = rd_sel;
                    sdram_addr_nxt = rd_addr_arr[rd_sel];
                    sdram_we_nxt   = 1'b0;
                    sdram_req_nxt  = 1'b1;
                    state_nxt      = ST_REQ;
                end
            end

            ST_REQ: begin
                if (sdram_ack) begin
                    sdram_req_nxt = 1'b0;
                    if (is_wr) begin
                        wr_ack_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        rd_ack_nxt[grant] = 1'b1;
                        // Controller may return data on the accepting edge.
                        if (sdram_valid) begin
                            rd_q_nxt            = sdram_q;
                            rd_valid_nxt[grant] = 1'b1;
                            state_nxt           = ST_IDLE;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                end
            end

            ST_DATA: begin
                // A stray sdram_ack here is ignored.
                if (sdram_valid) begin
                    rd_q_nxt            = sdram_q;
                    rd_valid_nxt[grant] = 1'b1;
                    state_nxt           = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Arbitration bookkeeping and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= PTR_W'(NUM_PORTS - 1);
            grant      <= '0;
            is_wr      <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            sdram_we   <= 1'b0;
            sdram_req  <= 1'b0;
            wr_ack     <= 1'b0;
            rd_ack     <= '0;
            rd_valid   <= '0;
            rd_q       <= '0;
        end else begin
            rr_ptr     <= rr_ptr_nxt;
            grant      <= grant_nxt;
            is_wr      <= is_wr_nxt;
            sdram_addr <= sdram_addr_nxt;
            sdram_data <= sdram_data_nxt;
            sdram_we   <= sdram_we_nxt;
            sdram_req  <= sdram_req_nxt;
            wr_ack     <= wr_ack_nxt;
            rd_ack     <= rd_ack_nxt;
            rd_valid   <= rd_valid_nxt;
            rd_q       <= rd_q_nxt;
        end
    end

endmodule
